// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: sums synapse bytes into a saturating,
// shift-leaking membrane potential and fires a spike followed by a refractory window.
module lif_neuron #(
  parameter int unsigned NUM_SYN       = 4,
  parameter int unsigned POT_W         = 12,
  parameter int unsigned LEAK_SHIFT    = 3,
  parameter int unsigned REFRAC_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [NUM_SYN*8-1:0]   syn_data_i,
  input  logic [POT_W-1:0]       threshold_i,
  output logic                   spike_o,
  output logic [POT_W-1:0]       potential_o,
  output logic                   refrac_o
);

  localparam int unsigned SUM_W  = 8 + $clog2(NUM_SYN);
  localparam int unsigned NEXT_W = POT_W + SUM_W;
  localparam int unsigned CNT_W  = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_e;

  state_e             state_q;
  logic [POT_W-1:0]   pot_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               spike_q;
  logic               refrac_q;

  logic [SUM_W-1:0]   sum_c;
  logic [POT_W-1:0]   leak_c;
  logic [NEXT_W-1:0]  next_full_c;
  logic [POT_W-1:0]   next_sat_c;
  logic               fire_c;

  // Full-width sum of all synapse bytes; SUM_W is wide enough to never wrap.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(NUM_SYN); k++) begin
      sum_c = sum_c + SUM_W'(syn_data_i[8*k +: 8]);
    end
  end

  // Leak is subtracted from pot itself, so the difference can never underflow.
  always_comb begin
    leak_c      = pot_q >> LEAK_SHIFT;
    next_full_c = NEXT_W'(pot_q - leak_c) + NEXT_W'(sum_c);
    if (|next_full_c[NEXT_W-1:POT_W]) begin
      next_sat_c = '1;
    end else begin
      next_sat_c = next_full_c[POT_W-1:0];
    end
    fire_c = (next_sat_c >= threshold_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= INTEGRATE;
      pot_q    <= '0;
      cnt_q    <= '0;
      spike_q  <= 1'b0;
      refrac_q <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      case (state_q)
        INTEGRATE: begin
          if (en_i) begin
            if (fire_c) begin
              spike_q <= 1'b1;
              pot_q   <= '0;
              if (REFRAC_CYCLES > 0) begin
                cnt_q    <= CNT_W'(REFRAC_CYCLES);
                state_q  <= REFRACTORY;
                refrac_q <= 1'b1;
              end
            end else begin
              pot_q <= next_sat_c;
            end
          end
        end
        REFRACTORY: begin
          // Input is ignored here; the counter alone decides when integration resumes.
          pot_q <= '0;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q    <= '0;
            state_q  <= INTEGRATE;
            refrac_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= INTEGRATE;
          pot_q    <= '0;
          cnt_q    <= '0;
          refrac_q <= 1'b0;
        end
      endcase
    end
  end

  assign spike_o     = spike_q;
  assign potential_o = pot_q;
  assign refrac_o    = refrac_q;

endmodule
